// File: rtl/shim_ads816x_pkg.sv
// Constants shared by the ADS816x shim blocks (frame sequencer and n_cs timing calculator).
package shim_ads816x_pkg;
  localparam int          OTF_CMD_BITS = 16;
  localparam logic [15:0] OTF_NOP      = 16'h0000;
  localparam int          MIN_CS_HIGH  = 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_GAP   = 2'd3
  } seq_state_e;

  // Full conversion-cycle time in ns for each model (1 / 0.5 / 0.25 MSPS parts).
  function automatic int model_cycle_ns(input int model);
    case (model)
      8:       return 1000;
      7:       return 2000;
      default: return 4000;
    endcase
  endfunction
endpackage

// File: rtl/shim_ads816x_adc_frame_seq_if.sv
// Command-in / sample-out streams of the ADS816x frame sequencer; slave is the sequencer side.
interface shim_ads816x_adc_frame_seq_if;
  import shim_ads816x_pkg::*;
  logic [OTF_CMD_BITS-1:0] cmd_data;
  logic                    cmd_valid;
  logic                    cmd_ready;
  logic [OTF_CMD_BITS-1:0] smp_data;
  logic                    smp_valid;
  logic                    smp_ready;

  modport slave  (input  cmd_data, cmd_valid, smp_ready,
                  output cmd_ready, smp_data, smp_valid);
  modport master (output cmd_data, cmd_valid, smp_ready,
                  input  cmd_ready, smp_data, smp_valid);
endinterface

// File: rtl/shim_ads816x_sample_fifo.sv
// Synchronous sample FIFO; extra pointer MSB distinguishes full from empty.
module shim_ads816x_sample_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end
endmodule

// File: rtl/shim_ads816x_adc_frame_seq.sv
// ADS816x frame sequencer: 1 load + 16 SPI bit cycles with n_cs low, then an n_cs-high gap.
// Optional SHIM_ADS816X_FRAME_CNT_EN adds a free-running frame_cnt output.
module shim_ads816x_adc_frame_seq
  import shim_ads816x_pkg::*;
#(
  parameter int ADS_MODEL_ID   = 8,
  parameter int OUT_FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       timing_done,
  input  logic       timing_lock_viol,
  input  logic [7:0] n_cs_high_time,
  shim_ads816x_adc_frame_seq_if.slave bus,
  output logic       n_cs,
  output logic       sclk_en,
  output logic       mosi,
  input  logic       miso,
  output logic       busy,
  output logic       overflow,
  output logic       timing_err,
  output logic [7:0] model_id
`ifdef SHIM_ADS816X_FRAME_CNT_EN
  ,
  output logic [31:0] frame_cnt
`endif
);
  seq_state_e        state, next_state;
  logic [3:0]        bit_cnt;
  logic [7:0]        gap_cnt, gap_len;
  logic [14:0]       tx_sr;
  logic [14:0]       rx_sr;
  logic [15:0]       load_word;
  logic              first_frame, stop_req;
  logic              go, shift_last, push, fifo_full, fifo_empty;

  assign go         = enable && timing_done && !timing_lock_viol;
  assign shift_last = (state == S_SHIFT) && (bit_cnt == 4'd0);
  assign push       = shift_last && !first_frame;
  assign load_word  = bus.cmd_valid ? bus.cmd_data : OTF_NOP;
  assign gap_len    = (n_cs_high_time < 8'(MIN_CS_HIGH)) ? 8'(MIN_CS_HIGH) : n_cs_high_time;
  assign model_id   = 8'(ADS_MODEL_ID);
  assign bus.smp_valid = !fifo_empty;

  always_comb begin
    next_state    = state;
    bus.cmd_ready = 1'b0;
    case (state)
      S_IDLE:  if (go) next_state = S_LOAD;
      S_LOAD: begin
        bus.cmd_ready = bus.cmd_valid;
        next_state    = S_SHIFT;
      end
      S_SHIFT: if (bit_cnt == 4'd0) next_state = S_GAP;
      S_GAP:   if (gap_cnt == 8'd0) next_state = (go && !stop_req) ? S_LOAD : S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Chip-select, clock gate and busy are registered copies of the next state so they align with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      n_cs        <= 1'b1;
      sclk_en     <= 1'b0;
      mosi        <= 1'b0;
      busy        <= 1'b0;
      bit_cnt     <= '0;
      gap_cnt     <= '0;
      tx_sr       <= '0;
      rx_sr       <= '0;
      first_frame <= 1'b1;
      stop_req    <= 1'b0;
      overflow    <= 1'b0;
      timing_err  <= 1'b0;
    end else begin
      state   <= next_state;
      n_cs    <= !(next_state == S_LOAD || next_state == S_SHIFT);
      sclk_en <= (next_state == S_SHIFT);
      busy    <= (next_state != S_IDLE);

      // A frame in flight always finishes; a dropped condition only ends the run after the gap.
      if (state == S_IDLE) stop_req <= 1'b0;
      else if (!go)        stop_req <= 1'b1;
      if (state != S_IDLE && (!timing_done || timing_lock_viol)) timing_err <= 1'b1;
      if (push && fifo_full) overflow <= 1'b1;

      case (state)
        S_LOAD: begin
          mosi    <= load_word[15];
          tx_sr   <= load_word[14:0];
          bit_cnt <= 4'(OTF_CMD_BITS - 1);
        end
        S_SHIFT: begin
          rx_sr <= {rx_sr[13:0], miso};
          if (bit_cnt == 4'd0) begin
            mosi        <= 1'b0;
            first_frame <= 1'b0;
            gap_cnt     <= gap_len - 8'd1;
          end else begin
            mosi    <= tx_sr[14];
            tx_sr   <= {tx_sr[13:0], 1'b0};
            bit_cnt <= bit_cnt - 4'd1;
          end
        end
        S_GAP: begin
          if (gap_cnt != 8'd0)            gap_cnt     <= gap_cnt - 8'd1;
          else if (next_state == S_IDLE) first_frame <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef SHIM_ADS816X_FRAME_CNT_EN
  always_ff @(posedge clk) begin
    if (reset)           frame_cnt <= '0;
    else if (shift_last) frame_cnt <= frame_cnt + 32'd1;
  end
`endif

  shim_ads816x_sample_fifo #(.DEPTH(OUT_FIFO_DEPTH), .WIDTH(OTF_CMD_BITS)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (bus.smp_valid && bus.smp_ready),
    .din   ({rx_sr, miso}),
    .dout  (bus.smp_data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );
endmodule
